// File: rtl/ctrl_poller.sv
// rtl/ctrl_poller.sv - serial poller for two shift-register game pads
// Purpose: periodically (or on request) latches both pads, clocks out eight
//          active-low button bits per pad and publishes them atomically.
// Ports:
//   clk_cpu        in   sole clock
//   rst            in   asynchronous active-high reset
//   en             in   enable automatic polling on the period tick
//   poll_req       in   single-cycle request for an immediate poll
//   ctrl_data[1:0] in   serial data from pad 0/1 (active-low, asynchronous)
//   ctrl_strobe    out  latch line, both bits identical
//   ctrl_out       out  shift clock, idle high, both bits identical
//   btn0/btn1      out  pad 0/1 buttons, active-high, A,B,Sel,Start,U,D,L,R
//   valid          out  one-cycle pulse when btn0/btn1 update
//   busy           out  high while a poll is in progress
module ctrl_poller #(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 29780
) (
  input  logic       clk_cpu,
  input  logic       rst,
  input  logic       en,
  input  logic       poll_req,
  input  logic [1:0] ctrl_data,
  output logic [1:0] ctrl_strobe,
  output logic [1:0] ctrl_out,
  output logic [7:0] btn0,
  output logic [7:0] btn1,
  output logic       valid,
  output logic       busy
);

  localparam int PW = $clog2(POLL_PERIOD);

  typedef enum logic [2:0] {
    IDLE, STROBE, SETTLE, CLK_LO, CLK_HI, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync1_q, sync2_q;
  logic [PW-1:0] period_q;
  logic [7:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh0_q, sh0_d, sh1_q, sh1_d;
  logic          tick, phase_last;

  assign tick       = (period_q == PW'(POLL_PERIOD - 1));
  assign phase_last = (phase_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    // every timed state advances the phase counter, wrapping on its last cycle
    if (state_q != IDLE && state_q != DONE) begin
      phase_d = phase_last ? 8'd0 : phase_q + 8'd1;
    end
    case (state_q)
      IDLE: begin
        phase_d = 8'd0;
        bit_d   = 3'd0;
        if (poll_req || (tick && en)) state_d = STROBE;
      end
      STROBE: if (phase_last) state_d = SETTLE;
      SETTLE: begin
        // bit 0 is presented by the pad as soon as the latch drops
        if (phase_last) begin
          sh0_d[0] = ~sync2_q[0];
          sh1_d[0] = ~sync2_q[1];
          bit_d    = 3'd1;
          state_d  = CLK_LO;
        end
      end
      CLK_LO: if (phase_last) state_d = CLK_HI;
      CLK_HI: begin
        if (phase_last) begin
          sh0_d[bit_q] = ~sync2_q[0];
          sh1_d[bit_q] = ~sync2_q[1];
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = CLK_LO;
          end
        end
      end
      DONE: begin
        phase_d = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      period_q    <= '0;
      phase_q     <= 8'd0;
      bit_q       <= 3'd0;
      sh0_q       <= 8'd0;
      sh1_q       <= 8'd0;
      ctrl_strobe <= 2'b00;
      ctrl_out    <= 2'b11;
      btn0        <= 8'd0;
      btn1        <= 8'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sync1_q     <= ctrl_data;
      sync2_q     <= sync1_q;
      period_q    <= tick ? '0 : period_q + PW'(1);
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      ctrl_strobe <= {2{state_d == STROBE}};
      ctrl_out    <= {2{state_d != CLK_LO}};
      busy        <= (state_d != IDLE);
      valid       <= (state_d == DONE);
      // both pads publish together, including the final bit sampled this edge
      if (state_d == DONE) begin
        btn0 <= sh0_d;
        btn1 <= sh1_d;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_poller.sv
// tb/tb_ctrl_poller.sv - scoreboard bench for ctrl_poller with two pad models
module tb_ctrl_poller;
  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 200;

  logic       clk_cpu = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       poll_req = 1'b0;
  logic [1:0] ctrl_data;
  logic [1:0] ctrl_strobe, ctrl_out;
  logic [7:0] btn0, btn1;
  logic       valid, busy;

  ctrl_poller #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .en(en), .poll_req(poll_req),
    .ctrl_data(ctrl_data), .ctrl_strobe(ctrl_strobe), .ctrl_out(ctrl_out),
    .btn0(btn0), .btn1(btn1), .valid(valid), .busy(busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk_cpu) cyc <= cyc + 1;

  // pad models: 4021-style shift register, active-low data, shift on rising clock
  logic [7:0] pad_btn [2];
  logic [3:0] idx [2] = '{4'd0, 4'd0};
  logic       prev_clk [2] = '{1'b1, 1'b1};
  bit         ovr = 1'b0;
  logic [1:0] ovr_val = 2'b11;

  always @(negedge clk_cpu) begin
    for (int p = 0; p < 2; p++) begin
      if (ctrl_strobe[p]) idx[p] <= 4'd0;
      else if (ctrl_out[p] && !prev_clk[p] && idx[p] < 4'd8) idx[p] <= idx[p] + 4'd1;
      prev_clk[p] <= ctrl_out[p];
    end
  end

  always_comb begin
    ctrl_data = 2'b11;
    for (int p = 0; p < 2; p++) begin
      if (ovr) ctrl_data[p] = ovr_val[p];
      else if (idx[p] < 4'd8) ctrl_data[p] = ~pad_btn[p][idx[p][2:0]];
      else ctrl_data[p] = 1'b0;
    end
  end

  // waveform monitor
  logic prev_strobe = 1'b0, prev_co = 1'b1, prev_busy = 1'b0;
  int strobe_rises = 0, strobe_rise_cyc = 0, strobe_run = 0, last_strobe_len = 0;
  int low_run = 0, low_pulses = 0, bad_low = 0;
  int busy_run = 0, last_busy_len = 0, valid_count = 0, split = 0;

  always @(negedge clk_cpu) begin
    prev_strobe <= ctrl_strobe[0];
    if (ctrl_strobe[0]) begin
      if (!prev_strobe) begin
        strobe_rises    <= strobe_rises + 1;
        strobe_rise_cyc <= cyc;
        strobe_run      <= 1;
      end else strobe_run <= strobe_run + 1;
    end else if (prev_strobe) last_strobe_len <= strobe_run;
    prev_co <= ctrl_out[0];
    if (!ctrl_out[0]) low_run <= prev_co ? 1 : low_run + 1;
    else if (!prev_co) begin
      low_pulses <= low_pulses + 1;
      if (low_run != CLK_DIV) bad_low <= bad_low + 1;
    end
    prev_busy <= busy;
    if (busy) busy_run <= prev_busy ? busy_run + 1 : 1;
    else if (prev_busy) last_busy_len <= busy_run;
    if (valid) valid_count <= valid_count + 1;
    if (ctrl_out[0] !== ctrl_out[1] || ctrl_strobe[0] !== ctrl_strobe[1]) split <= split + 1;
  end

  logic [15:0] exp_q [$];
  logic [15:0] exp_v;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_cpu);
      #1;
    end
  endtask

  task automatic pulse_req();
    step(1);
    poll_req = 1'b1;
    step(1);
    poll_req = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_cpu);
      #1;
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(3);
    total++; if (ctrl_out !== 2'b11) $display("FAIL reset_ctrl_out got %b want 11", ctrl_out); else passed++;
    total++; if (ctrl_strobe !== 2'b00) $display("FAIL reset_strobe got %b want 00", ctrl_strobe); else passed++;
    total++; if (btn0 !== 8'h00) $display("FAIL reset_btn0 got %h want 00", btn0); else passed++;
    total++; if (btn1 !== 8'h00) $display("FAIL reset_btn1 got %h want 00", btn1); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single_poll();
    bit got;
    int lp0, bl0, v0;
    pad_btn[0] = 8'h81;
    pad_btn[1] = 8'h00;
    lp0 = low_pulses; bl0 = bad_low; v0 = valid_count;
    exp_q.push_back({pad_btn[1], pad_btn[0]});
    pulse_req();
    wait_valid(200, got);
    total++;
    if (!got) $display("FAIL single_timeout got no valid want valid");
    else begin
      passed++;
      exp_v = exp_q.pop_front();
      total++; if (btn0 !== exp_v[7:0]) $display("FAIL single_btn0 got %h want %h", btn0, exp_v[7:0]); else passed++;
      total++; if (btn1 !== exp_v[15:8]) $display("FAIL single_btn1 got %h want %h", btn1, exp_v[15:8]); else passed++;
    end
    step(4);
    total++; if (last_busy_len != 16*CLK_DIV+1) $display("FAIL poll_len got %0d want %0d", last_busy_len, 16*CLK_DIV+1); else passed++;
    total++; if (last_strobe_len != CLK_DIV) $display("FAIL strobe_len got %0d want %0d", last_strobe_len, CLK_DIV); else passed++;
    total++; if (low_pulses - lp0 != 7) $display("FAIL low_pulses got %0d want 7", low_pulses - lp0); else passed++;
    total++; if (bad_low != bl0) $display("FAIL low_pulse_width got %0d bad want 0", bad_low - bl0); else passed++;
    total++; if (valid_count - v0 != 1) $display("FAIL single_valid_count got %0d want 1", valid_count - v0); else passed++;
    total++; if (ctrl_out !== 2'b11 || busy !== 1'b0) $display("FAIL idle_lines got out=%b busy=%b want 11/0", ctrl_out, busy); else passed++;
    total++; if (split != 0) $display("FAIL pad_lines_split got %0d want 0", split); else passed++;
  endtask

  task automatic test_period();
    bit got;
    int rel, t1, v0, r0;
    step(1);
    rst = 1'b1;
    en  = 1'b1;
    step(1);
    rst = 1'b0;
    rel = cyc;
    pad_btn[0] = 8'h0F;
    pad_btn[1] = 8'hF0;
    exp_q.push_back({pad_btn[1], pad_btn[0]});
    exp_q.push_back({pad_btn[1], pad_btn[0]});
    for (int k = 0; k < 2; k++) begin
      wait_valid(POLL_PERIOD + 100, got);
      total++;
      if (!got) $display("FAIL period_timeout poll %0d got no valid want valid", k);
      else begin
        passed++;
        exp_v = exp_q.pop_front();
        total++; if ({btn1, btn0} !== exp_v) $display("FAIL period_btns poll %0d got %h want %h", k, {btn1, btn0}, exp_v); else passed++;
        if (k == 0) begin
          t1 = strobe_rise_cyc;
          total++; if (t1 - rel != POLL_PERIOD) $display("FAIL first_tick got %0d want %0d", t1 - rel, POLL_PERIOD); else passed++;
        end else begin
          total++; if (strobe_rise_cyc - t1 != POLL_PERIOD) $display("FAIL poll_interval got %0d want %0d", strobe_rise_cyc - t1, POLL_PERIOD); else passed++;
        end
      end
    end
    en = 1'b0;
    pad_btn[0] = 8'h33;
    pad_btn[1] = 8'h44;
    v0 = valid_count; r0 = strobe_rises;
    step(2*POLL_PERIOD + 50);
    total++; if (valid_count != v0 || strobe_rises != r0) $display("FAIL en_off_polls got %0d polls want 0", strobe_rises - r0); else passed++;
    total++; if (btn0 !== 8'h0F || btn1 !== 8'hF0) $display("FAIL en_off_hold got %h/%h want 0f/f0", btn0, btn1); else passed++;
  endtask

  task automatic test_busy_drop();
    bit got;
    int v0, r0;
    pad_btn[0] = 8'h24;
    pad_btn[1] = 8'h99;
    v0 = valid_count; r0 = strobe_rises;
    exp_q.push_back({pad_btn[1], pad_btn[0]});
    pulse_req();
    step(20);
    pulse_req();
    wait_valid(200, got);
    total++;
    if (!got) $display("FAIL busy_drop_timeout got no valid want valid");
    else begin
      passed++;
      exp_v = exp_q.pop_front();
      total++; if ({btn1, btn0} !== exp_v) $display("FAIL busy_drop_btns got %h want %h", {btn1, btn0}, exp_v); else passed++;
    end
    step(100);
    total++; if (strobe_rises - r0 != 1) $display("FAIL busy_drop_strobes got %0d want 1", strobe_rises - r0); else passed++;
    total++; if (valid_count - v0 != 1) $display("FAIL busy_drop_valids got %0d want 1", valid_count - v0); else passed++;
  endtask

  task automatic test_reset_mid_poll();
    bit got, hit;
    int lp0, v0;
    pad_btn[0] = 8'h5A;
    pad_btn[1] = 8'hC3;
    lp0 = low_pulses; v0 = valid_count;
    pulse_req();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (low_pulses - lp0 >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    total++; if (!hit) $display("FAIL reach_bit3 got %0d pulses want 3", low_pulses - lp0); else passed++;
    step(1);
    rst = 1'b1;
    #1;
    total++; if (ctrl_out !== 2'b11 || ctrl_strobe !== 2'b00) $display("FAIL midrst_lines got out=%b stb=%b want 11/00", ctrl_out, ctrl_strobe); else passed++;
    total++; if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL midrst_flags got busy=%b valid=%b want 0/0", busy, valid); else passed++;
    total++; if (btn0 !== 8'h00 || btn1 !== 8'h00) $display("FAIL midrst_btns got %h/%h want 00/00", btn0, btn1); else passed++;
    step(2);
    rst = 1'b0;
    step(100);
    total++; if (valid_count != v0) $display("FAIL midrst_no_valid got %0d want 0", valid_count - v0); else passed++;
    exp_q.push_back({pad_btn[1], pad_btn[0]});
    pulse_req();
    wait_valid(200, got);
    total++;
    if (!got) $display("FAIL post_rst_timeout got no valid want valid");
    else begin
      passed++;
      exp_v = exp_q.pop_front();
      total++; if ({btn1, btn0} !== exp_v) $display("FAIL post_rst_btns got %h want %h", {btn1, btn0}, exp_v); else passed++;
    end
  endtask

  task automatic test_pads_const();
    bit got;
    logic [1:0] lv [2];
    lv[0] = 2'b11;
    lv[1] = 2'b00;
    ovr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ovr_val = lv[k];
      step(3);
      exp_q.push_back((lv[k] == 2'b11) ? 16'h0000 : 16'hFFFF);
      pulse_req();
      wait_valid(200, got);
      total++;
      if (!got) $display("FAIL const_timeout data=%b got no valid want valid", lv[k]);
      else begin
        passed++;
        exp_v = exp_q.pop_front();
        total++; if ({btn1, btn0} !== exp_v) $display("FAIL const_btns data=%b got %h want %h", lv[k], {btn1, btn0}, exp_v); else passed++;
      end
      step(5);
    end
    ovr = 1'b0;
  endtask

  initial begin
    pad_btn[0] = 8'h00;
    pad_btn[1] = 8'h00;
    test_reset();
    test_single_poll();
    test_period();
    test_busy_drop();
    test_reset_mid_poll();
    test_pads_const();
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_poller.md
CTRL_POLLER -- requirements
Module: ctrl_poller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6, meaning clk_cpu cycles per serial phase (legal range 4..255).
REQ-002 SHALL have parameter POLL_PERIOD, default 29780, meaning clk_cpu cycles between automatic polls (must exceed 16*CLK_DIV+4).
REQ-003 SHALL have port clk_cpu  input  1  sole clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  automatic polling enable.
REQ-006 SHALL have port poll_req  input  1  single-cycle request for an immediate poll.
REQ-007 SHALL have port ctrl_data  input  2  serial data from pads 0/1, active-low, asynchronous.
REQ-008 SHALL have port ctrl_strobe  output  2  latch line to both pads, both bits identical.
REQ-009 SHALL have port ctrl_out  output  2  shift clock to both pads, idle high, both bits identical.
REQ-010 SHALL have port btn0  output  8  pad 0 buttons, active-high, bit0..7 = A,B,Select,Start,Up,Down,Left,Right.
REQ-011 SHALL have port btn1  output  8  pad 1 buttons, same order as btn0.
REQ-012 SHALL have port valid  output  1  one-cycle pulse when btn0/btn1 update.
REQ-013 SHALL have port busy  output  1  high while a poll is in progress.

Function
REQ-014 SHALL pass ctrl_data through a 2-flop synchronizer per bit before any use.
REQ-015 SHALL run a free-running period counter 0..POLL_PERIOD-1 that wraps to 0 and emits a tick at POLL_PERIOD-1.
REQ-016 SHALL start a poll from IDLE on the cycle after (tick AND en) OR poll_req; triggers arriving while busy are dropped.
REQ-017 SHALL use states IDLE, STROBE, SETTLE, CLK_LO, CLK_HI, DONE, with a phase counter 0..CLK_DIV-1 and a bit counter 0..7.
REQ-018 STROBE: ctrl_strobe=2'b11 for CLK_DIV cycles, then SETTLE.
REQ-019 SETTLE: strobe low, ctrl_out high for CLK_DIV cycles; on its last cycle, sample synchronized bit 0 of each pad, then CLK_LO.
REQ-020 CLK_LO: ctrl_out=2'b00 for CLK_DIV cycles, then CLK_HI.
REQ-021 CLK_HI: ctrl_out=2'b11 for CLK_DIV cycles; on its last cycle, sample the next bit; after the bit 7 sample go to DONE, else CLK_LO.
REQ-022 Samples SHALL be stored inverted (pressed=1) into shift registers, bit k to position k.
REQ-023 DONE SHALL last one cycle: btn0/btn1 load both shift registers simultaneously, valid=1, then IDLE.
REQ-024 Poll length SHALL be 16*CLK_DIV+1 cycles, counted from the first STROBE cycle through DONE inclusive.
REQ-025 busy SHALL be 1 in every non-IDLE state.
REQ-026 btn0/btn1 SHALL hold their values between polls and never show a partially shifted poll.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On rst assertion, asynchronously: state=IDLE, counters=0, ctrl_strobe=0, ctrl_out=2'b11, btn0=btn1=0, valid=0, busy=0, synchronizers=2'b11.
REQ-029 Reset mid-poll SHALL abort the poll with no valid pulse; the first tick after release occurs POLL_PERIOD cycles after release.

Verification
REQ-030 CLK_DIV=4, poll_req pulse, pad0 model returns A and Right pressed, pad1 none -> 65-cycle poll, valid once, btn0=8'h81, btn1=8'h00.
REQ-031 Waveform check, CLK_DIV=4: strobe high exactly 4 cycles, seven ctrl_out low pulses of 4 cycles each, ctrl_out high at idle.
REQ-032 en=1, POLL_PERIOD=200, no poll_req -> polls start every 200 cycles; en=0 -> no polls, btn values held.
REQ-033 poll_req asserted during busy -> ignored: one valid pulse total, no restart of the strobe.
REQ-034 rst asserted during CLK_HI of bit 3 -> outputs at reset values immediately, no valid pulse; next poll returns the full correct pattern.
REQ-035 ctrl_data held 2'b11 (pads absent) -> btn0=btn1=8'h00; held 2'b00 -> btn0=btn1=8'hFF.
